// File: rtl/ili9341_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_pkg
// Purpose  : Shared word type and SPI engine state encoding for the ILI9341 TX.
// Revision : 1.0
// ============================================================================
package ili9341_pkg;

    localparam int LCD_WORD_W = 9;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } lcd_word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        HOLD = 3'd4,
        CSHI = 3'd5
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/ili9341_word_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_word_fifo
// Purpose  : Single-clock FIFO of lcd_word_t; registered flags, no bypass path.
// Revision : 1.0
// ============================================================================
module ili9341_word_fifo
    import ili9341_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  lcd_word_t              wdata,
    output lcd_word_t              rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    lcd_word_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (level == FULL_LVL);
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule
`default_nettype wire

// File: rtl/ili9341_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_spi_tx
// Purpose  : Buffers D/CX+byte words and shifts them out as 4-wire SPI mode 0.
// Revision : 1.0
// ============================================================================
module ili9341_spi_tx
    import ili9341_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int CS_HIGH    = 2
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_dc,
    input  logic [7:0]                  s_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        lcd_csx,
    output logic                        lcd_dcx,
    output logic                        lcd_sck,
    output logic                        lcd_sdi
);
    localparam int               CNT_MAX  = (CLK_DIV > CS_HIGH) ? CLK_DIV : CS_HIGH;
    localparam int               CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CSH_LAST = CNT_W'(CS_HIGH - 1);

    spi_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             csx_q, csx_d, sck_q, sck_d, dcx_q, dcx_d, sdi_q, sdi_d;

    logic      push, pop, load, fifo_full, fifo_empty;
    lcd_word_t fifo_wdata, fifo_rdata;

    assign s_ready    = !fifo_full && !ARESET;
    assign push       = s_valid && s_ready;
    assign fifo_wdata = '{dc: s_dc, data: s_data};
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign lcd_csx    = csx_q;
    assign lcd_sck    = sck_q;
    assign lcd_dcx    = dcx_q;
    assign lcd_sdi    = sdi_q;

    ili9341_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        csx_d   = csx_q;
        sck_d   = sck_q;
        dcx_d   = dcx_q;
        sdi_d   = sdi_q;
        load    = 1'b0;
        pop     = 1'b0;

        case (state_q)
            // An accepted push lands in the FIFO next cycle, when LOAD pops it.
            IDLE: if (!fifo_empty || push) state_d = LOAD;
            LOAD: load = 1'b1;
            LOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    sck_d   = 1'b1;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    sck_d = 1'b0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {shreg_q[6:0], 1'b0};
                        sdi_d   = shreg_q[6];
                        state_d = LOW;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d   = '0;
                    csx_d   = 1'b1;
                    state_d = CSHI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            CSHI: begin
                if (cnt_q == CSH_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by LOAD and the back-to-back reload at the end of bit 7.
        if (load) begin
            pop     = 1'b1;
            shreg_d = fifo_rdata.data;
            dcx_d   = fifo_rdata.dc;
            sdi_d   = fifo_rdata.data[7];
            csx_d   = 1'b0;
            sck_d   = 1'b0;
            bit_d   = 3'd0;
            cnt_d   = '0;
            state_d = LOW;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            csx_q   <= 1'b1;
            sck_q   <= 1'b0;
            dcx_q   <= 1'b0;
            sdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            csx_q   <= csx_d;
            sck_q   <= sck_d;
            dcx_q   <= dcx_d;
            sdi_q   <= sdi_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ili9341_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ili9341_spi_tx
// Purpose  : Drives two ili9341_spi_tx instances (CLK_DIV 2 and 1) and decodes
//            their pins as a panel would, against a queue of accepted words.
// Revision : 1.0
// ============================================================================
module tb_ili9341_spi_tx;
    import ili9341_pkg::*;

    localparam int CS_HIGH = 2;
    localparam int DEPTH   = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       vld [2];
    logic       dc  [2];
    logic [7:0] dat [2];
    logic       rdy [2];
    logic       busy[2];
    logic       csx [2];
    logic       dcx [2];
    logic       sck [2];
    logic       sdi [2];
    logic [4:0] lvl [2];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    int rise_cnt[2]    = '{0, 0};
    int frames[2]      = '{0, 0};
    int frame_bytes[2] = '{0, 0};
    int max_lvl[2]     = '{0, 0};

    logic [LCD_WORD_W-1:0] exp0[$];
    logic [LCD_WORD_W-1:0] exp1[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CD = (g == 0) ? 2 : 1;

        ili9341_spi_tx #(
            .CLK_DIV    (CD),
            .FIFO_DEPTH (DEPTH),
            .CS_HIGH    (CS_HIGH)
        ) u_dut (
            .ACLK       (clk),
            .ARESET     (rst[g]),
            .s_valid    (vld[g]),
            .s_ready    (rdy[g]),
            .s_dc       (dc[g]),
            .s_data     (dat[g]),
            .busy       (busy[g]),
            .fifo_level (lvl[g]),
            .lcd_csx    (csx[g]),
            .lcd_dcx    (dcx[g]),
            .lcd_sck    (sck[g]),
            .lcd_sdi    (sdi[g])
        );

        // Panel-side decoder: samples every cycle just after the falling clock.
        int cyc = 0, nbits = 0, nbytes = 0, pend = 0;
        int t_fall = 0, t_rise = 0, t_first = 0, t_srise = 0, t_sfall = 0;
        bit seen_rise = 1'b0;
        logic p_sck = 1'b0, p_csx = 1'b1, p_dcx = 1'b0, p_sdi = 1'b0, wdc = 1'b0;
        logic [7:0] shift = 8'd0;
        logic [LCD_WORD_W-1:0] word, want;

        always begin
            @(negedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                check_eq("ready_rule", 32'(rdy[g]), 32'(!rst[g] && (lvl[g] < 5'd16)));
                if (int'(lvl[g]) > max_lvl[g]) max_lvl[g] = int'(lvl[g]);
                if (csx[g]) check_eq("sck_idle_low", 32'(sck[g]), 0);
                else        check_eq("busy_in_frame", 32'(busy[g]), 1);
                if (p_sck && sck[g]) begin
                    check_eq("dcx_stable_hi", 32'(dcx[g]), 32'(p_dcx));
                    check_eq("sdi_stable_hi", 32'(sdi[g]), 32'(p_sdi));
                end
                if (p_csx && !csx[g]) begin
                    if (seen_rise) check_eq("csx_high_min", 32'((cyc - t_rise) >= CS_HIGH), 1);
                    t_fall = cyc;
                    nbits  = 0;
                    nbytes = 0;
                    frames[g]++;
                end
                if (!p_sck && sck[g] && !csx[g]) begin
                    rise_cnt[g]++;
                    if (nbits == 0) begin
                        if (nbytes == 0) check_eq("first_edge", 32'(cyc - t_fall), CD);
                        else             check_eq("byte_period", 32'(cyc - t_first), 16 * CD);
                        t_first = cyc;
                        wdc     = dcx[g];
                    end else begin
                        check_eq("sck_low_len", 32'(cyc - t_sfall), CD);
                        check_eq("dc_const", 32'(dcx[g]), 32'(wdc));
                    end
                    shift   = {shift[6:0], sdi[g]};
                    t_srise = cyc;
                    nbits++;
                    if (nbits == 8) begin
                        word = {wdc, shift};
                        pend = (g == 0) ? exp0.size() : exp1.size();
                        check_eq("sb_pending", 32'(pend > 0), 1);
                        if (pend > 0) begin
                            want = (g == 0) ? exp0.pop_front() : exp1.pop_front();
                            check_eq("sb_word", 32'(word), 32'(want));
                        end
                        nbits = 0;
                        nbytes++;
                    end
                end
                if (p_sck && !sck[g] && !csx[g]) begin
                    check_eq("sck_high_len", 32'(cyc - t_srise), CD);
                    t_sfall = cyc;
                end
                if (!p_csx && csx[g]) begin
                    // A frame cut short mid-byte (reset) has no fixed length.
                    if (nbits == 0) check_eq("csx_low_len", 32'(cyc - t_fall), nbytes * 16 * CD + CD);
                    frame_bytes[g] = nbytes;
                    nbits     = 0;
                    t_rise    = cyc;
                    seen_rise = 1'b1;
                end
            end
            p_sck = sck[g];
            p_csx = csx[g];
            p_dcx = dcx[g];
            p_sdi = sdi[g];
        end
    end

    // Call at a falling edge; leaves vld high when hold is set.
    task automatic push_word(input int u, input logic d, input logic [7:0] b, input bit hold);
        int n = 0;
        vld[u] = 1'b1;
        dc[u]  = d;
        dat[u] = b;
        while (!rdy[u] && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", 32'(rdy[u]), 1);
        if (u == 0) exp0.push_back({d, b});
        else        exp1.push_back({d, b});
        @(negedge clk);
        if (!hold) vld[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int n = 0;
        while (busy[u] && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_reached", 32'(busy[u]), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rises(input int u, input int k);
        int n = 0;
        int base = rise_cnt[u];
        while (rise_cnt[u] < base + k && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("rises_seen", 32'(rise_cnt[u] >= base + k), 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            vld[i] = 1'b0;
            dc[i]  = 1'b0;
            dat[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_csx", 32'(csx[i]), 1);
            check_eq("rst_sck", 32'(sck[i]), 0);
            check_eq("rst_dcx", 32'(dcx[i]), 0);
            check_eq("rst_sdi", 32'(sdi[i]), 0);
            check_eq("rst_busy", 32'(busy[i]), 0);
            check_eq("rst_level", 32'(lvl[i]), 0);
            check_eq("rst_ready", 32'(rdy[i]), 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        check_eq("ready_after_rst0", 32'(rdy[0]), 1);
        check_eq("ready_after_rst1", 32'(rdy[1]), 1);
        mon_en = 1'b1;
        @(negedge clk);

        // Single command 0x2A: latency and bit order.
        f0 = frames[0];
        push_word(0, 1'b0, 8'h2A, 1'b0);
        check_eq("t1_level_T1", 32'(lvl[0]), 1);
        check_eq("t1_csx_T1", 32'(csx[0]), 1);
        @(negedge clk);
        check_eq("t1_csx_T2", 32'(csx[0]), 0);
        check_eq("t1_dcx_T2", 32'(dcx[0]), 0);
        check_eq("t1_sdi_T2", 32'(sdi[0]), 0);
        check_eq("t1_level_T2", 32'(lvl[0]), 0);
        wait_idle(0);
        check_eq("t1_frames", 32'(frames[0] - f0), 1);
        check_eq("t1_frame_bytes", 32'(frame_bytes[0]), 1);

        // Command plus four data bytes in one CSX frame.
        f0 = frames[0];
        push_word(0, 1'b0, 8'h2C, 1'b1);
        push_word(0, 1'b1, 8'h12, 1'b1);
        push_word(0, 1'b1, 8'h34, 1'b1);
        push_word(0, 1'b1, 8'h56, 1'b1);
        push_word(0, 1'b1, 8'h78, 1'b0);
        wait_idle(0);
        check_eq("t2_frames", 32'(frames[0] - f0), 1);
        check_eq("t2_frame_bytes", 32'(frame_bytes[0]), 5);

        // Twenty words with valid held high: FIFO fills to its depth.
        max_lvl[0] = 0;
        for (int j = 0; j < 20; j++)
            push_word(0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), j != 19);
        wait_idle(0);
        check_eq("t3_max_level", 32'(max_lvl[0]), DEPTH);
        check_eq("t3_frame_bytes", 32'(frame_bytes[0]), 20);

        // Reset in the middle of 0xA5, then a clean 0x3C.
        push_word(0, 1'b1, 8'hA5, 1'b0);
        wait_rises(0, 3);
        rst[0] = 1'b1;
        @(negedge clk);
        check_eq("t4_csx", 32'(csx[0]), 1);
        check_eq("t4_sck", 32'(sck[0]), 0);
        check_eq("t4_dcx", 32'(dcx[0]), 0);
        check_eq("t4_sdi", 32'(sdi[0]), 0);
        check_eq("t4_level", 32'(lvl[0]), 0);
        check_eq("t4_busy", 32'(busy[0]), 0);
        check_eq("t4_ready_in_rst", 32'(rdy[0]), 0);
        rst[0] = 1'b0;
        exp0.delete();
        #1;
        check_eq("t4_ready_after", 32'(rdy[0]), 1);
        @(negedge clk);
        push_word(0, 1'b0, 8'h3C, 1'b0);
        wait_idle(0);
        check_eq("t4_frame_bytes", 32'(frame_bytes[0]), 1);

        // Two words separated by idle give two CSX frames.
        f0 = frames[0];
        push_word(0, 1'b0, 8'h11, 1'b0);
        wait_idle(0);
        push_word(0, 1'b0, 8'h29, 1'b0);
        wait_idle(0);
        check_eq("t5_frames", 32'(frames[0] - f0), 2);

        // CLK_DIV=1 instance, back-to-back burst.
        push_word(1, 1'b0, 8'hB1, 1'b1);
        push_word(1, 1'b1, 8'h5A, 1'b1);
        push_word(1, 1'b1, 8'h81, 1'b1);
        push_word(1, 1'b1, 8'h7E, 1'b0);
        wait_idle(1);
        check_eq("t6_frame_bytes", 32'(frame_bytes[1]), 4);

        // Random bursts with random gaps on both instances.
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < 8; k++) begin
                int len;
                len = $urandom_range(1, 5);
                for (int j = 0; j < len; j++) begin
                    push_word(u, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b0);
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clk);
                end
                if ($urandom_range(0, 1) == 0) wait_idle(u);
            end
        end

        wait_idle(0);
        wait_idle(1);
        check_eq("sb_drained0", 32'(exp0.size()), 0);
        check_eq("sb_drained1", 32'(exp1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ili9341_spi_tx.md
# ili9341_spi_tx

Serial transmit engine for the ILI9341 panel. It sits directly downstream of the ili9341_if AXI4-Lite register block. It accepts 9-bit command/data words (D/CX flag plus byte) over a valid/ready stream and buffers them in a small FIFO. It serialises each word onto the panel's 4-wire SPI pins (CSX, D/CX, SCL, SDA), SPI mode 0, MSB first, keeping CSX low across back-to-back words.

## Interface
- CLK_DIV, 4: SCK half-period in ACLK cycles; legal range ≥1.
- FIFO_DEPTH, 16: word FIFO depth; must be a power of 2, ≥2.
- CS_HIGH, 2: minimum ACLK cycles CSX stays high between bursts; legal range ≥1.
- ACLK  in  1  single clock for the whole block.
- ARESET  in  1  synchronous, active-high reset.
- s_valid  in  1  word offered.
- s_ready  out  1  FIFO can accept; equals !full, forced 0 while ARESET=1.
- s_dc  in  1  0 = command, 1 = data.
- s_data  in  8  byte to send.
- busy  out  1  high when the FSM is not IDLE or the FIFO is not empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  words currently buffered.
- lcd_csx  out  1  chip select, active low.
- lcd_dcx  out  1  D/CX line.
- lcd_sck  out  1  serial clock, idles low.
- lcd_sdi  out  1  serial data to panel.

## Operation
- Handshake: a word is written into the FIFO on any cycle where s_valid and s_ready are both high. s_valid/s_dc/s_data may change only after acceptance.
- A push into a full FIFO is impossible, because s_ready=0 even if a pop occurs in the same cycle. There is no bypass: a word pushed into an empty FIFO is visible to the FSM next cycle.
- FSM states:
  - IDLE → LOAD when FIFO not empty.
  - LOAD (1 cycle): pop word; shift register ← data; lcd_dcx ← dc; lcd_csx ← 0; lcd_sdi ← bit7; lcd_sck ← 0; bit counter ← 0 → LOW.
  - LOW: lcd_sck=0 for CLK_DIV cycles → HIGH.
  - HIGH: lcd_sck=1 for CLK_DIV cycles. At phase end:
    - bits 0..6: lcd_sck ← 0, shift next bit onto lcd_sdi → LOW.
    - bit 7, FIFO not empty: lcd_sck ← 0, pop and load next word (dc, bit7) in the same cycle, CSX stays low → LOW.
    - bit 7, FIFO empty → HOLD.
  - HOLD: lcd_sck=0, lcd_csx=0 for CLK_DIV cycles → CSHI.
  - CSHI: lcd_csx=1 for CS_HIGH cycles → IDLE.
- lcd_dcx and lcd_sdi change only on cycles where lcd_sck is or becomes 0. They never change while lcd_sck=1.
- All lcd_* outputs are registered (no combinational path to pins).
- Reset, including mid-byte: FSM → IDLE, FIFO emptied, counters cleared, next cycle lcd_csx=1, lcd_sck=0, lcd_dcx=0, lcd_sdi=0, busy=0, fifo_level=0. The truncated byte is discarded by the panel on CSX rise.

## Timing
- Reset values: lcd_csx=1, lcd_sck=0, lcd_dcx=0, lcd_sdi=0, busy=0, fifo_level=0, s_ready=0 during reset and 1 on the first cycle after.
- First-byte latency from IDLE/empty: handshake at cycle T; FIFO holds the word at T+1; LOAD at T+1; lcd_csx low, lcd_dcx and lcd_sdi valid from T+2.
- Byte period: exactly 16·CLK_DIV cycles from CSX-low/LOAD to the next load when words are back-to-back. The first rising SCK edge comes CLK_DIV cycles after the load.
- Burst tail: last falling SCK edge, then CLK_DIV cycles of hold, then CSX high for ≥CS_HIGH cycles before the next LOAD.
- fifo_level updates the cycle after each push/pop; simultaneous push+pop leaves it unchanged.

## Structure
- Shared package ili9341_pkg: lcd_word_t (packed struct {dc, data[7:0]}), spi_state_t enum (IDLE, LOAD, LOW, HIGH, HOLD, CSHI), LCD_WORD_W=9.
- Sub-module ili9341_word_fifo: synchronous single-clock FIFO of lcd_word_t, parameter DEPTH. Ports: push, pop, wdata, rdata, full, empty, level; synchronous active-high reset.
- ili9341_spi_tx instantiates the FIFO plus the FSM, half-period counter and 3-bit bit counter.

## Test plan
- CLK_DIV=2, push cmd 0x2A (dc=0) → lcd_csx low at T+2, lcd_dcx=0. Eight SCK rising edges sample 0,0,1,0,1,0,1,0; CSX rises 32+2 cycles after falling; busy drops after CS_HIGH.
- Push 0x2C (dc=0) then data 0x12,0x34,0x56,0x78 (dc=1) back-to-back → CSX low continuously for 5×32 cycles. D/CX goes 0→1 only while SCK=0; bytes arrive in order.
- Push 20 words with s_valid held high → s_ready drops once fifo_level=16. All 20 bytes are transmitted in order with no loss or duplication.
- Reset asserted after the 3rd SCK rising edge of byte 0xA5 → next cycle lcd_csx=1, lcd_sck=0, fifo_level=0, busy=0. A subsequent 0x3C transmits correctly.
- Push 0x11, wait until IDLE, push 0x29 → CSX high for ≥CS_HIGH cycles between the two bytes; each byte is a separate CSX frame.
- CLK_DIV=1 → SCK period is 2 ACLK cycles and the byte period is 16 cycles; data is stable across every rising edge.
